uart_recv: RTL and testbench

UART receiver for 8N1 frames, the downstream counterpart of the UART transmitter. It takes the asynchronous serial line, synchronises it to `sys_clk` and detects the start bit. It samples each bit at mid-period, checks the stop bit, and presents each received byte with a one-cycle strobe. It sits between the board RX pin (or a TX loopback in test benches) and the byte consumer.

---
 rtl/uart_recv_if.sv | 26 ++
 rtl/uart_recv.sv | 142 ++++++++++++++
 tb/tb_uart_recv.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_recv_if.sv
// Serial receive channel: the RX line going in and the received-byte
// strobes coming out. The receiver uses the slave view; whatever drives the
// line and consumes bytes uses the master view.
interface uart_recv_if;
  logic       uart_rxd;
  logic [7:0] uart_data;
  logic       uart_done;
  logic       frame_err;
  logic       rx_busy;

  modport master (
    output uart_rxd,
    input  uart_data,
    input  uart_done,
    input  frame_err,
    input  rx_busy
  );

  modport slave (
    input  uart_rxd,
    output uart_data,
    output uart_done,
    output frame_err,
    output rx_busy
  );
endinterface

// File: rtl/uart_recv.sv
// 8N1 UART receiver. The line is synchronised into sys_clk and a falling
// edge starts a frame. Each bit is sampled at its mid point, then the stop
// bit is checked. A good frame updates uart_data with a one-cycle uart_done;
// a low stop bit gives a one-cycle frame_err and leaves uart_data alone.
// sys_rst_n is an active-high asynchronous reset, despite its name.
module uart_recv #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  uart_recv_if.slave  rx
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int HALF    = BPS_CNT / 2;

  localparam logic [15:0] CNT_LAST = 16'(BPS_CNT - 1);
  localparam logic [15:0] CNT_MID  = 16'(HALF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state;
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_d;
  logic        start_edge;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic [7:0]  data_q;
  logic        done_q;
  logic        err_q;
  logic        busy_q;

  // Two-flop synchroniser plus one delay stage for edge detection; all three
  // come out of reset high so releasing reset cannot look like a start bit.
  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx.uart_rxd;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign start_edge = rx_d & ~rx_s2;

  // Frame FSM with its bit-period counter, bit counter, shift register and
  // all registered outputs. The strobes default low every cycle so they can
  // only ever last one cycle. STOP returns to IDLE at mid stop bit so that a
  // start bit immediately following the stop bit is still caught.
  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      state     <= IDLE;
      clk_cnt   <= 16'd0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      if (state == IDLE) begin
        clk_cnt <= 16'd0;
      end else if (clk_cnt == CNT_LAST) begin
        clk_cnt <= 16'd0;
      end else begin
        clk_cnt <= clk_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (start_edge) begin
            state  <= START;
            busy_q <= 1'b1;
          end
        end

        START: begin
          if (clk_cnt == CNT_MID && rx_s2) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            clk_cnt <= 16'd0;
          end else if (clk_cnt == CNT_LAST) begin
            state   <= DATA;
            bit_cnt <= 3'd0;
          end
        end

        DATA: begin
          if (clk_cnt == CNT_MID) begin
            shift_reg <= {rx_s2, shift_reg[7:1]};
          end
          if (clk_cnt == CNT_LAST) begin
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

        STOP: begin
          if (clk_cnt == CNT_MID) begin
            if (rx_s2) begin
              data_q <= shift_reg;
              done_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state   <= IDLE;
            busy_q  <= 1'b0;
            clk_cnt <= 16'd0;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx.uart_data = data_q;
  assign rx.uart_done = done_q;
  assign rx.frame_err = err_q;
  assign rx.rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv at 16 clocks per bit. A behavioural serial
// transmitter drives the RX line, and a negedge monitor collects strobes,
// received bytes and busy cycles for each scenario task to compare against.
module tb_uart_recv;

  localparam int BPS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_recv_if bus ();

  uart_recv #(
    .CLK_FREQ(16),
    .UART_BPS(1)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst),
    .rx       (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  int done_count    = 0;
  int err_count     = 0;
  int busy_cycles   = 0;
  int overlap_count = 0;
  int long_pulses   = 0;
  logic prev_strobe = 1'b0;
  logic [7:0] rx_q[$];

  // Free-running clock.
  always #5 clk = ~clk;

  // Strobe monitor sampling away from the active edge.
  always @(negedge clk) begin
    if (bus.uart_done) begin
      done_count++;
      rx_q.push_back(bus.uart_data);
    end
    if (bus.frame_err) err_count++;
    if (bus.uart_done && bus.frame_err) overlap_count++;
    if (prev_strobe && (bus.uart_done || bus.frame_err)) long_pulses++;
    prev_strobe = bus.uart_done | bus.frame_err;
    if (bus.rx_busy) busy_cycles++;
  end

  task automatic drive_bit(input logic v, input int n);
    bus.uart_rxd = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural 8N1 transmitter, LSB first, no trailing idle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0, BPS);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BPS);
    drive_bit(stop_bit, BPS);
    bus.uart_rxd = 1'b1;
  endtask

  function automatic logic [7:0] q_at(input int idx);
    if (rx_q.size() > idx) return rx_q[idx];
    return 8'hxx;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.uart_rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (bus.uart_data !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_data got %h expected 00", bus.uart_data);
    end
    tests_run++;
    if (bus.uart_done !== 1'b0 || bus.frame_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes got done=%b err=%b expected 0/0", bus.uart_done, bus.frame_err);
    end
    tests_run++;
    if (bus.rx_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_busy got %b expected 0", bus.rx_busy);
    end
    rst = 1'b0;
    drive_bit(1'b1, 10);
    tests_run++;
    if (bus.rx_busy !== 1'b0 || done_count != 0 || err_count != 0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_idle got busy=%b done=%0d err=%0d expected 0/0/0", bus.rx_busy, done_count, err_count);
    end
  endtask

  task automatic test_basic_byte();
    int d0 = done_count;
    int e0 = err_count;
    int b0 = busy_cycles;
    int idx = rx_q.size();
    send_frame(8'h55, 1'b1);
    drive_bit(1'b1, 20);
    tests_run++;
    if (done_count - d0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL basic_done_count got %0d expected 1", done_count - d0);
    end
    tests_run++;
    if (q_at(idx) !== 8'h55) begin
      tests_failed++;
      $display("[TB] FAIL basic_strobe_data got %h expected 55", q_at(idx));
    end
    tests_run++;
    if (bus.uart_data !== 8'h55) begin
      tests_failed++;
      $display("[TB] FAIL basic_data_hold got %h expected 55", bus.uart_data);
    end
    tests_run++;
    if (err_count - e0 != 0) begin
      tests_failed++;
      $display("[TB] FAIL basic_frame_err got %0d expected 0", err_count - e0);
    end
    tests_run++;
    if (busy_cycles - b0 != 9 * BPS + 9) begin
      tests_failed++;
      $display("[TB] FAIL basic_busy_cycles got %0d expected %0d", busy_cycles - b0, 9 * BPS + 9);
    end
  endtask

  task automatic test_back_to_back();
    int d0 = done_count;
    int e0 = err_count;
    int idx = rx_q.size();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    drive_bit(1'b1, 20);
    tests_run++;
    if (done_count - d0 != 2) begin
      tests_failed++;
      $display("[TB] FAIL b2b_done_count got %0d expected 2", done_count - d0);
    end
    tests_run++;
    if (q_at(idx) !== 8'hA3) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first got %h expected a3", q_at(idx));
    end
    tests_run++;
    if (q_at(idx + 1) !== 8'h0F) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second got %h expected 0f", q_at(idx + 1));
    end
    tests_run++;
    if (err_count - e0 != 0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_frame_err got %0d expected 0", err_count - e0);
    end
  endtask

  task automatic test_false_start();
    int d0 = done_count;
    int e0 = err_count;
    int b0 = busy_cycles;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 30);
    tests_run++;
    if (busy_cycles - b0 != 9) begin
      tests_failed++;
      $display("[TB] FAIL false_start_busy got %0d expected 9", busy_cycles - b0);
    end
    tests_run++;
    if (bus.rx_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL false_start_idle got %b expected 0", bus.rx_busy);
    end
    tests_run++;
    if (done_count != d0 || err_count != e0) begin
      tests_failed++;
      $display("[TB] FAIL false_start_strobes got done=%0d err=%0d expected 0/0", done_count - d0, err_count - e0);
    end
    tests_run++;
    if (bus.uart_data !== 8'h0F) begin
      tests_failed++;
      $display("[TB] FAIL false_start_data got %h expected 0f", bus.uart_data);
    end
  endtask

  task automatic test_frame_error();
    int d0 = done_count;
    int e0 = err_count;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b0);
    drive_bit(1'b1, 20);
    tests_run++;
    if (err_count - e0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL ferr_count got %0d expected 1", err_count - e0);
    end
    tests_run++;
    if (done_count - d0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL ferr_done_count got %0d expected 1", done_count - d0);
    end
    tests_run++;
    if (bus.uart_data !== 8'h3C) begin
      tests_failed++;
      $display("[TB] FAIL ferr_data got %h expected 3c", bus.uart_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0 = done_count;
    int e0 = err_count;
    logic [7:0] partial = 8'h5A;
    drive_bit(1'b0, BPS);
    for (int i = 0; i < 4; i++) drive_bit(partial[i], BPS);
    drive_bit(partial[4], 8);
    bus.uart_rxd = 1'b1;
    rst = 1'b1;
    #2;
    tests_run++;
    if (bus.uart_data !== 8'h00 || bus.rx_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_outputs got data=%h busy=%b expected 00/0", bus.uart_data, bus.rx_busy);
    end
    @(negedge clk);
    tests_run++;
    if (bus.uart_done !== 1'b0 || bus.frame_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_strobes got done=%b err=%b expected 0/0", bus.uart_done, bus.frame_err);
    end
    @(posedge clk);
    #1;
    drive_bit(1'b1, 3);
    rst = 1'b0;
    drive_bit(1'b1, 30);
    tests_run++;
    if (done_count != d0 || err_count != e0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_aborted got done=%0d err=%0d expected 0/0", done_count - d0, err_count - e0);
    end
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1, 20);
    tests_run++;
    if (bus.uart_data !== 8'h81 || done_count - d0 != 1) begin
      tests_failed++;
      $display("[TB] FAIL midrst_next got data=%h done=%0d expected 81/1", bus.uart_data, done_count - d0);
    end
  endtask

  task automatic test_loopback();
    int d0 = done_count;
    int e0 = err_count;
    int idx = rx_q.size();
    int bad = 0;
    for (int b = 0; b < 256; b++) send_frame(8'(b), 1'b1);
    drive_bit(1'b1, 20);
    tests_run++;
    if (done_count - d0 != 256) begin
      tests_failed++;
      $display("[TB] FAIL loop_count got %0d expected 256", done_count - d0);
    end
    for (int i = 0; i < 256; i++) begin
      if (q_at(idx + i) !== 8'(i)) begin
        if (bad < 5) $display("[TB] FAIL loop_byte_%0d got %h expected %h", i, q_at(idx + i), 8'(i));
        bad++;
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL loop_order got %0d wrong bytes expected 0", bad);
    end
    tests_run++;
    if (err_count - e0 != 0) begin
      tests_failed++;
      $display("[TB] FAIL loop_frame_err got %0d expected 0", err_count - e0);
    end
    tests_run++;
    if (overlap_count != 0 || long_pulses != 0) begin
      tests_failed++;
      $display("[TB] FAIL strobe_shape got overlap=%0d long=%0d expected 0/0", overlap_count, long_pulses);
    end
  endtask

  // Scenario sequence.
  initial begin
    bus.uart_rxd = 1'b1;
    test_reset();
    test_basic_byte();
    test_back_to_back();
    test_false_start();
    test_frame_error();
    test_reset_mid_frame();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
